dmem_arbiter: RTL and testbench

//  Shares the single data_memory port between two requesters: M0 (processor load/store path) and
//  M1 (host program/data loader or debug access). Ownership is registered and round-robin.
//  A burst limit bounds how long one owner can hold the port. Read data returns one cycle after grant.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data-memory port
// between the core load/store path (M0) and the host loader/debug path (M1).
// Ownership is registered; a grant is the owner's request qualified by reset.
// A burst counter forces a handover once the owner has used BURST_MAX grants
// while the other side is waiting.
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // Counter must hold 0..BURST_MAX-1; keep at least one bit for BURST_MAX=1.
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  state_t        state;
  logic          last;   // 0: M0 owned last, 1: M1 owned last
  logic [CW-1:0] cnt;
  logic          rv0;
  logic          rv1;

  // Grants are gated by rst so nothing reaches the memory in a reset cycle.
  assign m0_gnt = (state == OWN0) & m0_req & ~rst;
  assign m1_gnt = (state == OWN1) & m1_req & ~rst;

  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign mem_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
  assign mem_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);

  // Read data is shared; rvalid marks which requester it belongs to.
  // A response still in flight when reset arrives is suppressed.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = rv0 & ~rst;
  assign m1_rvalid = rv1 & ~rst;
  assign owner     = state;

  // Ownership FSM, burst counter, fairness bit and read-response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      rv0 <= m0_gnt & ~m0_we;
      rv1 <= m1_gnt & ~m1_we;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_req && m1_req) state <= last ? OWN0 : OWN1;
          else if (m0_req)      state <= OWN0;
          else if (m1_req)      state <= OWN1;
        end
        OWN0: begin
          if (m0_req) begin
            if (cnt == CNT_LAST && m1_req) begin
              state <= OWN1;
              cnt   <= '0;
              last  <= 1'b0;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state <= m1_req ? OWN1 : IDLE;
            cnt   <= '0;
            last  <= 1'b0;
          end
        end
        OWN1: begin
          if (m1_req) begin
            if (cnt == CNT_LAST && m0_req) begin
              state <= OWN0;
              cnt   <= '0;
              last  <= 1'b1;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state <= m0_req ? OWN0 : IDLE;
            cnt   <= '0;
            last  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed steps in one initial block, a small
// synchronous memory model, and per-master queues of expected read data.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] mem [0:63];
  bit running = 1'b1;

  dmem_arbiter #(.DW(DW), .AW(AW), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous memory macro model.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard: pop expected read data whenever a master sees rvalid.
  always @(negedge clk) begin
    if (running) begin
      chk("one_gnt", 64'(m0_gnt & m1_gnt), 64'd0);
      if (m0_rvalid) begin
        if (q0.size() == 0) chk("m0_rvalid_unexpected", 64'd1, 64'd0);
        else chk("m0_rdata", 64'(m0_rdata), 64'(q0.pop_front()));
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) chk("m1_rvalid_unexpected", 64'd1, 64'd0);
        else chk("m1_rdata", 64'(m1_rdata), 64'(q1.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h04] = 32'hDEADBEEF;

    // T1: reset held two cycles with both masters requesting writes.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h2;
    for (int i = 0; i < 2; i++) begin
      next(); settle();
      chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
      chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
    end
    rst = 1'b0;
    settle();
    chk("rel1_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rel1_owner", 64'(owner), 64'd0);

    // T3: continuous contention, bursts of four, no gap at handovers.
    for (int i = 0; i < 12; i++) begin
      next(); settle();
      chk("burst_m0_gnt", 64'(m0_gnt), 64'(((i / 4) % 2) == 0));
      chk("burst_m1_gnt", 64'(m1_gnt), 64'(((i / 4) % 2) == 1));
      chk("burst_mem_addr", 64'(mem_addr), (((i / 4) % 2) == 0) ? 64'h40 : 64'h44);
    end
    next();
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    settle();
    chk("drop_owner", 64'(owner), 64'd2);
    chk("drop_m1_gnt", 64'(m1_gnt), 64'd0);
    next(); settle();
    chk("idle_owner", 64'(owner), 64'd0);

    // T2: single read by M0 with one-cycle arbitration bubble.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    settle();
    chk("t2_bubble_gnt", 64'(m0_gnt), 64'd0);
    next(); settle();
    chk("t2_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("t2_mem_addr", 64'(mem_addr), 64'h10);
    chk("t2_mem_we", 64'(mem_we), 64'd0);
    q0.push_back(32'hDEADBEEF);
    next();
    m0_req = 1'b0;
    settle();
    chk("t2_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("t2_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);

    // T4: M1 writes 0x1234 to 0x20 and reads it back.
    next();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234;
    settle();
    chk("t4_bubble_gnt", 64'(m1_gnt), 64'd0);
    next(); settle();
    chk("t4_wr_gnt", 64'(m1_gnt), 64'd1);
    chk("t4_mem_we", 64'(mem_we), 64'd1);
    chk("t4_mem_wdata", 64'(mem_wdata), 64'h1234);
    next();
    m1_we = 1'b0;
    settle();
    chk("t4_rd_gnt", 64'(m1_gnt), 64'd1);
    chk("t4_rd_mem_we", 64'(mem_we), 64'd0);
    q1.push_back(32'h1234);
    next();
    m1_req = 1'b0;
    settle();
    chk("t4_m1_rvalid", 64'(m1_rvalid), 64'd1);
    chk("t4_m0_rvalid", 64'(m0_rvalid), 64'd0);

    // T5: M0 releases after two grants; later M1 request sees a bubble.
    next();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h48; m0_wdata = 32'h5;
    settle();
    next(); settle();
    chk("t5_gnt1", 64'(m0_gnt), 64'd1);
    chk("t5_owner", 64'(owner), 64'd1);
    next(); settle();
    chk("t5_gnt2", 64'(m0_gnt), 64'd1);
    next();
    m0_req = 1'b0;
    settle();
    chk("t5_rel_owner", 64'(owner), 64'd1);
    chk("t5_rel_gnt", 64'(m0_gnt), 64'd0);
    next();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4C; m1_wdata = 32'h6;
    settle();
    chk("t5_idle_owner", 64'(owner), 64'd0);
    chk("t5_m1_bubble", 64'(m1_gnt), 64'd0);
    next(); settle();
    chk("t5_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("t5_m1_owner", 64'(owner), 64'd2);
    next();
    m1_req = 1'b0;
    settle();
    next(); settle();
    chk("t5_end_owner", 64'(owner), 64'd0);

    // T6: reset the cycle after a read grant; response and write are dropped.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    settle();
    next(); settle();
    chk("t6_m0_gnt", 64'(m0_gnt), 64'd1);
    next();
    rst = 1'b1; m0_we = 1'b1; m0_addr = 32'h50; m0_wdata = 32'h99;
    settle();
    chk("t6_rst_rvalid", 64'(m0_rvalid), 64'd0);
    chk("t6_rst_gnt", 64'(m0_gnt), 64'd0);
    chk("t6_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t6_rst_mem_en", 64'(mem_en), 64'd0);
    next();
    rst = 1'b0; m0_req = 1'b0;
    settle();
    chk("t6_owner", 64'(owner), 64'd0);
    chk("t6_rvalid_after", 64'(m0_rvalid), 64'd0);
    next(); settle();
    chk("t6_mem_not_written", 64'(mem[6'h14]), 64'd0);

    @(negedge clk);
    running = 1'b0;
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
